// File: rtl/fp_addsub_issuer.sv
// fp_addsub_issuer: queues host add/sub requests and issues them one at a time
// to the FP add/sub unit over a start/done handshake, with a timeout watchdog.
// Optional build macro ISSUER_STATS_EN adds saturating issue/timeout counters.
module fp_addsub_issuer #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_mode,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    output logic        add_start,
    output logic        mode,
    output logic [31:0] op1,
    output logic [31:0] op2,
    input  logic [31:0] add_result,
    input  logic        add_done,
    input  logic        add_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_overflow,
    output logic        rsp_timeout,
    output logic        busy
`ifdef ISSUER_STATS_EN
    ,
    output logic [15:0] stat_issued,
    output logic [15:0] stat_timeouts
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        logic        mode;
        logic [31:0] op1;
        logic [31:0] op2;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    req_t          fifo_mem [FIFO_DEPTH];
    req_t          head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          push, pop, done_hit, tout_hit;

    assign head = fifo_mem[rd_ptr];

    // Next-state, FIFO pop/count and WAIT-exit decisions
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        pop      = 1'b0;
        done_hit = 1'b0;
        tout_hit = 1'b0;
        push     = req_valid && req_ready;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // done takes priority over a timeout in the same cycle
                if (add_done) begin
                    done_hit = 1'b1;
                    state_d  = RESP;
                end else if (timer_q == TIMER_LAST) begin
                    tout_hit = 1'b1;
                    state_d  = RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {req_mode, req_op1, req_op2};
    end

    // State, pointers, issued operands and registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            count_q      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            req_ready    <= 1'b1;
            add_start    <= 1'b0;
            mode         <= 1'b0;
            op1          <= '0;
            op2          <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_timeout  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            req_ready <= (count_d != FULL_CNT);
            add_start <= (state_d == ISSUE);
            rsp_valid <= (state_d == RESP);
            busy      <= (state_d != IDLE) || (count_d != '0);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                mode   <= head.mode;
                op1    <= head.op1;
                op2    <= head.op2;
            end
            if (done_hit) begin
                rsp_result   <= add_result;
                rsp_overflow <= add_overflow;
                rsp_timeout  <= 1'b0;
            end else if (tout_hit) begin
                rsp_result   <= '0;
                rsp_overflow <= 1'b0;
                rsp_timeout  <= 1'b1;
            end
        end
    end

`ifdef ISSUER_STATS_EN
    // Saturating counters of issued ops and timed-out ops
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stat_issued   <= '0;
            stat_timeouts <= '0;
        end else begin
            if (state_q == ISSUE && stat_issued != 16'hFFFF)
                stat_issued <= stat_issued + 16'd1;
            if (tout_hit && stat_timeouts != 16'hFFFF)
                stat_timeouts <= stat_timeouts + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_addsub_issuer.sv
// Bench for fp_addsub_issuer: host driver, add/sub unit responder and a
// response scoreboard; expected responses come from the requests the bench sent.
module tb_fp_addsub_issuer;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_mode = 1'b0;
    logic [31:0] req_op1 = '0;
    logic [31:0] req_op2 = '0;
    logic        add_start;
    logic        mode;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] add_result = '0;
    logic        add_done = 1'b0;
    logic        add_overflow = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic        rsp_overflow;
    logic        rsp_timeout;
    logic        busy;
`ifdef ISSUER_STATS_EN
    logic [15:0] stat_issued;
    logic [15:0] stat_timeouts;
`endif

    fp_addsub_issuer dut (
        .clk(clk), .n_rst(n_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_op1(req_op1), .req_op2(req_op2),
        .add_start(add_start), .mode(mode), .op1(op1), .op2(op2),
        .add_result(add_result), .add_done(add_done), .add_overflow(add_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout), .busy(busy)
`ifdef ISSUER_STATS_EN
        , .stat_issued(stat_issued), .stat_timeouts(stat_timeouts)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int rsp_cnt = 0;
    int resp_lat = 1;
    int skip_cnt = 0;
    bit lat_rand = 1'b0;
    bit rdy_rand = 1'b0;
    logic [64:0] exp_iss[$];
    logic [33:0] exp_rsp[$];
    bit          pending = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_res = '0;
    logic        pend_ovf = 1'b0;

    // Stand-in for the add/sub unit: 1.25 + 1.5 is answered exactly, anything else
    // gets an arbitrary but reproducible pattern.
    function automatic logic [31:0] unit_result(input logic m, input logic [31:0] a, input logic [31:0] b);
        if (!m && a == 32'h3FA00000 && b == 32'h3FC00000) return 32'h40300000;
        return a ^ {b[15:0], b[31:16]} ^ {31'd0, m};
    endfunction

    function automatic logic unit_ovf(input logic m, input logic [31:0] a, input logic [31:0] b);
        return a[31] ^ b[0] ^ m;
    endfunction

    // Responder: answers add_start after resp_lat WAIT cycles, or never (skip_cnt)
    always @(negedge clk) begin : responder
        logic [64:0] h;
        int l;
        add_done = 1'b0;
        if (pending) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                add_done     = 1'b1;
                add_result   = pend_res;
                add_overflow = pend_ovf;
                pending      = 1'b0;
            end
        end
        if (n_rst && add_start) begin
            checks++;
            if (exp_iss.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected got op1=%h op2=%h", op1, op2);
            end else begin
                h = exp_iss.pop_front();
                if ({mode, op1, op2} !== h) begin
                    errors++;
                    $display("FAIL issue_order got=%h exp=%h", {mode, op1, op2}, h);
                end
                l = lat_rand ? int'($urandom_range(1, 6)) : resp_lat;
                if (skip_cnt > 0) begin
                    skip_cnt--;
                    exp_rsp.push_back({32'h0, 1'b0, 1'b1});
                end else begin
                    pending  = 1'b1;
                    pend_cnt = l;
                    pend_res = unit_result(h[64], h[63:32], h[31:0]);
                    pend_ovf = unit_ovf(h[64], h[63:32], h[31:0]);
                    // done must land within TMO WAIT cycles, otherwise the op times out
                    if (l > TMO) exp_rsp.push_back({32'h0, 1'b0, 1'b1});
                    else         exp_rsp.push_back({pend_res, pend_ovf, 1'b0});
                end
            end
        end
    end

    // Randomised host backpressure
    always @(negedge clk) begin
        if (rdy_rand) rsp_ready = ($urandom_range(0, 3) != 0);
    end

    // Scoreboard: every accepted response must match the oldest outstanding request
    always @(negedge clk) begin : scoreboard
        logic [33:0] e;
        #1;
        if (n_rst && rsp_valid && rsp_ready) begin
            checks++;
            if (exp_rsp.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected got result=%h", rsp_result);
            end else begin
                e = exp_rsp.pop_front();
                if ({rsp_result, rsp_overflow, rsp_timeout} !== e) begin
                    errors++;
                    $display("FAIL rsp_data got=%h exp=%h", {rsp_result, rsp_overflow, rsp_timeout}, e);
                end
            end
            rsp_cnt++;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic push_req(input logic m, input logic [31:0] a, input logic [31:0] b);
        bit ok = 1'b0;
        req_valid = 1'b1; req_mode = m; req_op1 = a; req_op2 = b;
        for (int i = 0; i < 400; i++) begin
            if (req_ready) begin
                @(posedge clk);
                exp_iss.push_back({m, a, b});
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            errors++; checks++;
            $display("FAIL push_timeout req_ready=%b exp=1", req_ready);
            @(posedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic push_rand();
        push_req(1'($urandom_range(0, 1)), $urandom, $urandom);
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && !pending && exp_rsp.size() == 0 && exp_iss.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL idle_timeout busy=%b outstanding=%0d exp=0", busy, exp_rsp.size());
        end
    endtask

    task automatic test_reset();
        #2 n_rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({add_start, mode, op1, op2, rsp_valid, rsp_result, rsp_overflow, rsp_timeout, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {add_start, mode, op1, op2, rsp_valid, rsp_result, rsp_overflow, rsp_timeout, busy});
        end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
`ifdef ISSUER_STATS_EN
        checks++;
        if ({stat_issued, stat_timeouts} !== 32'h0) begin
            errors++; $display("FAIL reset_stats got=%h exp=0", {stat_issued, stat_timeouts});
        end
`endif
        n_rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset_idle busy=%b req_ready=%b exp 0/1", busy, req_ready);
        end
    endtask

    task automatic test_single_add();
        resp_lat = 1; rsp_ready = 1'b1;
        push_req(1'b0, 32'h3FA00000, 32'h3FC00000);          // cycle 1 (IDLE pop)
        checks++;
        if (add_start !== 1'b0) begin errors++; $display("FAIL start_early got=%b exp=0", add_start); end
        @(negedge clk);                                        // cycle 2 (ISSUE)
        checks++;
        if (add_start !== 1'b1) begin errors++; $display("FAIL start_pulse got=%b exp=1", add_start); end
        checks++;
        if ({mode, op1, op2} !== {1'b0, 32'h3FA00000, 32'h3FC00000}) begin
            errors++; $display("FAIL issue_ops got=%h exp=%h", {mode, op1, op2}, {1'b0, 32'h3FA00000, 32'h3FC00000});
        end
        @(negedge clk);                                        // cycle 3 (WAIT)
        checks++;
        if (add_start !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL wait_cycle start=%b rsp_valid=%b exp 0/0", add_start, rsp_valid);
        end
        @(negedge clk);                                        // cycle 4 (RESP)
        checks++;
        if ({rsp_valid, rsp_result, rsp_timeout} !== {1'b1, 32'h40300000, 1'b0}) begin
            errors++; $display("FAIL single_rsp got v=%b r=%h t=%b exp v=1 r=40300000 t=0",
                               rsp_valid, rsp_result, rsp_timeout);
        end
        wait_idle(50);
    endtask

    task automatic test_fifo_full();
        int r0 = rsp_cnt;
        resp_lat = 20; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_rand();
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL fifo_3of4_ready got=%b exp=1", req_ready); end
        push_rand();
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL fifo_full_ready got=%b exp=0", req_ready); end
        checks++;
        if (rsp_cnt - r0 !== 0) begin errors++; $display("FAIL fifo_early_rsp got=%0d exp=0", rsp_cnt - r0); end
        push_rand();
        checks++;
        if (rsp_cnt - r0 < 1) begin errors++; $display("FAIL fifo_accept_before_pop rsps=%0d exp>=1", rsp_cnt - r0); end
        wait_idle(600);
        checks++;
        if (rsp_cnt - r0 !== 6) begin errors++; $display("FAIL fifo_rsp_count got=%0d exp=6", rsp_cnt - r0); end
        resp_lat = 1;
    endtask

    task automatic test_timeout();
        resp_lat = 1; rsp_ready = 1'b1; skip_cnt = 1;
        push_rand();
        push_rand();                                           // returns in the ISSUE cycle of op 1
        checks++;
        if (add_start !== 1'b1) begin errors++; $display("FAIL tmo_issue got=%b exp=1", add_start); end
        for (int k = 1; k <= TMO + 1; k++) begin
            @(negedge clk);
            if (k == TMO) begin
                checks++;
                if (rsp_valid !== 1'b0) begin errors++; $display("FAIL tmo_early got=%b exp=0", rsp_valid); end
            end
            if (k == TMO + 1) begin
                checks++;
                if ({rsp_valid, rsp_result, rsp_overflow, rsp_timeout} !== {1'b1, 32'h0, 1'b0, 1'b1}) begin
                    errors++; $display("FAIL tmo_rsp got v=%b r=%h o=%b t=%b exp v=1 r=0 o=0 t=1",
                                       rsp_valid, rsp_result, rsp_overflow, rsp_timeout);
                end
            end
        end
        wait_idle(100);
        resp_lat = TMO;       // done in the final WAIT cycle
        push_rand();
        wait_idle(200);
        resp_lat = TMO + 1;   // one cycle too late
        push_rand();
        wait_idle(200);
        resp_lat = 1;
    endtask

    task automatic test_back_to_back_stall();
        logic [33:0] held;
        bit seen = 1'b0;
        resp_lat = 1; rsp_ready = 1'b0;
        push_rand();
        push_rand();
        for (int i = 0; i < 20 && !seen; i++) begin
            if (rsp_valid) seen = 1'b1; else @(negedge clk);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL bp_no_rsp got=0 exp=1"); end
        held = {rsp_result, rsp_overflow, rsp_timeout};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, add_start, rsp_result, rsp_overflow, rsp_timeout} !== {1'b1, 1'b0, held}) begin
                errors++; $display("FAIL bp_hold cyc=%0d got v=%b s=%b d=%h exp v=1 s=0 d=%h",
                                   i, rsp_valid, add_start, {rsp_result, rsp_overflow, rsp_timeout}, held);
            end
        end
        rsp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (add_start) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL bp_next_issue got=0 exp=1"); end
        wait_idle(50);
    endtask

    task automatic test_random();
        int g;
        lat_rand = 1'b1; rdy_rand = 1'b1;
        for (int i = 0; i < 24; i++) begin
            g = int'($urandom_range(0, 2));
            for (int j = 0; j < g; j++) @(negedge clk);
            push_rand();
        end
        wait_idle(2000);
        lat_rand = 1'b0; rdy_rand = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        int bad = 0;
        resp_lat = 10; rsp_ready = 1'b1;
        push_rand();
        push_rand();
        push_rand();                                           // op 1 in WAIT, 2 queued
        repeat (2) @(negedge clk);
        n_rst = 1'b0;
        #1;
        checks++;
        if ({add_start, mode, op1, op2, rsp_valid, rsp_result, rsp_overflow, rsp_timeout, busy} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs got=%h exp=0",
                     {add_start, mode, op1, op2, rsp_valid, rsp_result, rsp_overflow, rsp_timeout, busy});
        end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_req_ready got=%b exp=1", req_ready); end
        exp_iss.delete();
        exp_rsp.delete();
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rsp_valid || add_start) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL late_done_activity got=%0d exp=0", bad); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        wait_idle(50);
        resp_lat = 1;
    endtask

`ifdef ISSUER_STATS_EN
    task automatic test_stats();
        resp_lat = 2; skip_cnt = 1; rsp_ready = 1'b1;
        push_rand();
        push_rand();
        push_rand();
        wait_idle(400);
        checks++;
        if (stat_issued !== 16'd3) begin errors++; $display("FAIL stat_issued got=%0d exp=3", stat_issued); end
        checks++;
        if (stat_timeouts !== 16'd1) begin errors++; $display("FAIL stat_timeouts got=%0d exp=1", stat_timeouts); end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL global_timeout time=%0t", $time);
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_single_add();
        test_fifo_full();
        test_timeout();
        test_back_to_back_stall();
        test_random();
        test_reset_mid_wait();
`ifdef ISSUER_STATS_EN
        test_stats();
`endif
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
